// File: rtl/cic_filter.sv
// -----------------------------------------------------------------------------
// cic_filter
//   Three-stage Hogenauer CIC decimator with differential delay 1 and a
//   programmable power-of-two decimation ratio R = 2^os_sel (1..128).
//   The integrators run on every clk.
//   The combs and the output register advance only on an output event:
//   a clk_div strobe, or every cycle when os_sel = 0.
//   The comb result is divided by R^3 with an arithmetic shift, so the DC
//   gain is exactly 1.
//
// Ports
//   clk      : full-rate sample clock, the only clock
//   reset_n  : asynchronous, active-low reset of all state and the output
//   clk_div  : one-cycle decimation strobe (ignored when os_sel = 0)
//   os_sel   : decimation select, R = 2^os_sel, quasi-static
//   data_in  : signed input sample, taken on every rising clk edge
//   data_out : signed decimated output, registered and held between events
// -----------------------------------------------------------------------------
module cic_filter #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_div,
  input  logic [2:0]    os_sel,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);

  localparam int NSTAGES = 3;
  // Bit growth for 3 stages at R = 128 is 3 * 7 = 21 bits.
  localparam int GROWTH  = 21;
  localparam int W       = DW + GROWTH;

  // ---------------------------------------------------------------------------
  // Integrator section
  // All sums wrap modulo 2^W on purpose. The comb differences cancel the
  // wrap as long as the true filter output fits in W bits, and it always
  // does because of the growth allowance above.
  // ---------------------------------------------------------------------------
  logic signed [W-1:0] data_ext;
  logic signed [W-1:0] integ_reg [NSTAGES];

  assign data_ext = {{GROWTH{data_in[DW-1]}}, data_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        integ_reg[k] <= '0;
      end
    end else begin
      integ_reg[0] <= integ_reg[0] + data_ext;
      for (int k = 1; k < NSTAGES; k++) begin
        integ_reg[k] <= integ_reg[k] + integ_reg[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comb section
  // The combs are evaluated combinationally from the newest integrator value.
  // The comb delay registers only capture on an output event. This makes the
  // differential delay one decimated sample, i.e. R input samples.
  // ---------------------------------------------------------------------------
  logic                out_event;
  logic signed [W-1:0] dly_reg [NSTAGES];
  logic signed [W-1:0] c1;
  logic signed [W-1:0] c2;
  logic signed [W-1:0] c3;

  // With os_sel = 0 the strobe is meaningless, so every edge is an event.
  assign out_event = (os_sel == 3'd0) | clk_div;

  assign c1 = integ_reg[NSTAGES-1] - dly_reg[0];
  assign c2 = c1 - dly_reg[1];
  assign c3 = c2 - dly_reg[2];

  // ---------------------------------------------------------------------------
  // Gain normalisation
  // The CIC gain is R^3 = 2^(3*os_sel). The shift amount is formed as
  // 2*os_sel + os_sel, which fits in 5 bits (maximum 21).
  // Only the low DW bits of the shifted result are kept. They are exact,
  // because the normalised output cannot exceed the input range.
  // ---------------------------------------------------------------------------
  logic [4:0]    shift_amt;
  logic [DW-1:0] data_out_next;

  assign shift_amt     = {1'b0, os_sel, 1'b0} + {2'b00, os_sel};
  assign data_out_next = DW'(c3 >>> shift_amt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        dly_reg[k] <= '0;
      end
      data_out <= '0;
    end else if (out_event) begin
      dly_reg[0] <= integ_reg[NSTAGES-1];
      dly_reg[1] <= c1;
      dly_reg[2] <= c2;
      data_out   <= data_out_next;
    end
  end

endmodule

// File: tb/tb_cic_filter.sv
// -----------------------------------------------------------------------------
// tb_cic_filter
//   Self-checking bench for cic_filter.
//   - A table of DC vectors: constant input, settling time, expected output.
//   - Hand-written sequences: reset, impulse pass-through, Nyquist null,
//     and a mid-run reset with a ratio change.
//   - Randomised runs at every ratio. They are checked against a reference
//     that convolves the input history with the CIC impulse response (three
//     boxcars of length R), then divides by R^3.
// -----------------------------------------------------------------------------
module tb_cic_filter;

  localparam int DW = 16;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b1;
  logic          clk_div  = 1'b0;
  logic [2:0]    os_sel   = 3'd0;
  logic [DW-1:0] data_in  = '0;
  logic [DW-1:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Impulse response of three cascaded length-R boxcars.
  int h  [0:383];
  // Input history: xh[n] is the sample presented before edge n after reset.
  int xh [0:1023];

  typedef struct {
    int os;
    int din;
    int ncyc;
    int expv;
  } dc_vec_t;

  dc_vec_t tbl [8];

  cic_filter #(.DW(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_div  (clk_div),
    .os_sel   (os_sel),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(expv));
    end
  endtask

  task automatic check_near(input string name, input logic [DW-1:0] act, input int expv, input int tol);
    int a;
    a = int'($signed(act));
    n_cmp++;
    if (a < expv - tol || a > expv + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, a, expv, tol);
    end
  endtask

  // Strobe at edge p, then every r edges.
  function automatic logic strobe_at(input int n, input int r, input int p);
    return (n >= p) && (((n - p) % r) == 0);
  endfunction

  // Holds reset for two edges, then releases it with the new ratio.
  // The next edge is edge 1 after reset.
  task automatic do_reset(input int os);
    reset_n = 1'b0;
    clk_div = 1'b0;
    tick();
    tick();
    os_sel  = 3'(os);
    reset_n = 1'b1;
  endtask

  task automatic build_h(input int r);
    int h2 [0:255];
    for (int j = 0; j < 384; j++) h[j] = 0;
    for (int j = 0; j < 256; j++) h2[j] = 0;
    for (int a = 0; a < r; a++)
      for (int b = 0; b < r; b++)
        h2[a+b]++;
    for (int j = 0; j < 2*r-1; j++)
      for (int c = 0; c < r; c++)
        h[j+c] += h2[j];
  endtask

  // Output at the event on edge n. Samples reach the combs three edges
  // after they are presented.
  function automatic logic [DW-1:0] model_out(input int n, input int r, input int s);
    longint acc;
    longint sh;
    acc = 0;
    for (int j = 0; j < 3*r-2; j++) begin
      int idx;
      idx = n - 3 - j;
      if (idx >= 1) acc += longint'(h[j]) * longint'(xh[idx]);
    end
    sh = acc >>> (3*s);
    return sh[DW-1:0];
  endfunction

  task automatic run_random(input int os, input int ncyc, input bit full);
    int r, p, x, bad0;
    logic [DW-1:0] exp_hold;
    r = 1 << os;
    p = $urandom_range(1, 3);
    bad0 = n_bad;
    build_h(r);
    do_reset(os);
    exp_hold = '0;
    for (int n = 1; n <= ncyc; n++) begin
      if (full) x = int'($urandom_range(0, 65535)) - 32768;
      else      x = int'($urandom_range(0, 2000)) - 1000;
      xh[n]   = x;
      data_in = DW'(x);
      if (os == 0) clk_div = 1'($urandom_range(0, 1));
      else         clk_div = strobe_at(n, r, p);
      tick();
      if (os == 0 || strobe_at(n, r, p)) exp_hold = model_out(n, r, os);
      check("random", data_out, exp_hold);
    end
    clk_div = 1'b0;
    $display("random os_sel=%0d cycles=%0d phase=%0d full=%0d errors=%0d", os, ncyc, p, full, n_bad - bad0);
  endtask

  initial begin
    tbl[0] = '{os: 2, din:   1000, ncyc:   40, expv:   1000};
    tbl[1] = '{os: 7, din: -32768, ncyc: 2000, expv: -32768};
    tbl[2] = '{os: 1, din:     -1, ncyc:   20, expv:     -1};
    tbl[3] = '{os: 3, din:  12345, ncyc:   60, expv:  12345};
    tbl[4] = '{os: 0, din:     -7, ncyc:   10, expv:     -7};
    tbl[5] = '{os: 5, din:  32767, ncyc:  400, expv:  32767};
    tbl[6] = '{os: 6, din: -20000, ncyc:  900, expv: -20000};
    tbl[7] = '{os: 4, din:      0, ncyc:  100, expv:      0};

    // ---- Reset: output held at 0, even with data and strobes present ----
    #2;
    reset_n = 1'b0;
    data_in = DW'(1234);
    os_sel  = 3'd0;
    clk_div = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("reset_hold", data_out, '0);
    end
    data_in = '0;
    os_sel  = 3'd2;
    clk_div = 1'b0;
    reset_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      clk_div = strobe_at(n, 4, 1);
      tick();
      check("post_reset_zero", data_out, '0);
    end
    clk_div = 1'b0;
    $display("reset sequence done");

    // ---- DC vector table ----
    for (int t = 0; t < 8; t++) begin
      int r;
      r = 1 << tbl[t].os;
      do_reset(tbl[t].os);
      for (int n = 1; n <= tbl[t].ncyc; n++) begin
        data_in = DW'(tbl[t].din);
        clk_div = strobe_at(n, r, 1);
        tick();
      end
      clk_div = 1'b0;
      check("dc_table", data_out, DW'(tbl[t].expv));
      $display("dc os_sel=%0d din=%0d out=%0d", tbl[t].os, tbl[t].din, $signed(data_out));
    end

    // ---- Impulse pass-through at os_sel = 0 (3-edge latency) ----
    do_reset(0);
    data_in = '0;
    for (int n = 1; n <= 5; n++) tick();
    for (int n = 6; n <= 11; n++) begin
      data_in = (n == 6) ? DW'(500) : '0;
      tick();
      check("impulse", data_out, (n == 9) ? DW'(500) : '0);
    end
    $display("impulse sequence done");

    // ---- Nyquist null at os_sel = 1 ----
    begin
      int ns;
      ns = 0;
      do_reset(1);
      for (int n = 1; n <= 30; n++) begin
        data_in = (n % 2 == 1) ? DW'(8000) : DW'(-8000);
        clk_div = strobe_at(n, 2, 1);
        tick();
        if (strobe_at(n, 2, 1)) begin
          ns++;
          if (ns >= 4) check_near("nyquist", data_out, 0, 1);
        end
      end
      clk_div = 1'b0;
      $display("nyquist sequence done");
    end

    // ---- Mid-run reset, then ratio change ----
    do_reset(2);
    for (int n = 1; n <= 30; n++) begin
      data_in = DW'(1000);
      clk_div = strobe_at(n, 4, 1);
      tick();
      if (n == 13 || n == 30) check("midrun_dc", data_out, DW'(1000));
    end
    #3;
    reset_n = 1'b0;
    clk_div = 1'b1;
    #1;
    check("async_reset", data_out, '0);
    tick();
    check("reset_strobe_ignored", data_out, '0);
    os_sel  = 3'd3;
    data_in = DW'(-200);
    reset_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      clk_div = strobe_at(n, 8, 1);
      tick();
      if (n == 25 || n == 40) check("ratio_change", data_out, DW'(-200));
    end
    clk_div = 1'b0;
    $display("mid-run reset sequence done");

    // ---- Randomised runs against the reference ----
    for (int os = 0; os < 8; os++) begin
      run_random(os, 3*(1 << os) + 40, 1'b1);
    end
    run_random(2, 80, 1'b0);
    run_random(6, 250, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
